// File: rtl/spam1_fetch_pkg.sv
// Shared types and constants for the SPAM-1 instruction fetch/jump sequencer.
package spam1_fetch_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_FETCH,
        ST_EXEC,
        ST_TGT,
        ST_LDHI,
        ST_LDLO
    } fetch_state_t;

    localparam logic [3:0] JMP_NIBBLE_DEF = 4'hF;
    localparam int unsigned COND_W = 4;

    // An empty condition mask means "always"; otherwise any selected flag set takes the jump.
    function automatic logic jump_taken(input logic [COND_W-1:0] cond_mask,
                                        input logic [COND_W-1:0] flags);
        return (cond_mask == '0) || (|(cond_mask & flags));
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// PC / program-ROM / PC-load bus between the fetch sequencer (master) and its surroundings.
interface fetch_sequencer_if #(
    parameter int unsigned AWIDTH = 15
);
    import spam1_fetch_pkg::*;

    logic [7:0]          PCHI;
    logic [7:0]          PCLO;
    logic [7:0]          rom_hi_data;
    logic [7:0]          rom_lo_data;
    logic [COND_W-1:0]   flags;
    logic                hold;

    logic [AWIDTH-1:0]   rom_address;
    logic                _rom_out;
    logic                pc_count_en;
    logic                _PCHITMPin;
    logic                _PCLOin;
    logic                _PCHIin;
    logic [7:0]          D;
    logic [7:0]          IR_HI;
    logic [7:0]          IR_LO;
    logic                ir_valid;

    modport master (
        input  PCHI, PCLO, rom_hi_data, rom_lo_data, flags, hold,
        output rom_address, _rom_out, pc_count_en, _PCHITMPin, _PCLOin, _PCHIin,
               D, IR_HI, IR_LO, ir_valid
    );

    modport slave (
        output PCHI, PCLO, rom_hi_data, rom_lo_data, flags, hold,
        input  rom_address, _rom_out, pc_count_en, _PCHITMPin, _PCLOin, _PCHIin,
               D, IR_HI, IR_LO, ir_valid
    );

endinterface

// File: rtl/fetch_sequencer_reset_wait_counter.sv
// Post-reset idle down-counter: holds off the first fetch for RESET_WAIT cycles.
module reset_wait_counter #(
    parameter int unsigned RESET_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic done
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 4'(RESET_WAIT);
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/jump sequencer: fetches {hi,lo} from the ROM pair at PC and loads jump targets into PC.
module fetch_sequencer
    import spam1_fetch_pkg::*;
#(
    parameter int unsigned AWIDTH     = 15,
    parameter logic [3:0]  JMP_NIBBLE = JMP_NIBBLE_DEF,
    parameter int unsigned RESET_WAIT = 2
) (
    input  logic              CP,
    input  logic              MR,
    fetch_sequencer_if.master bus
);

    fetch_state_t state;
    fetch_state_t next_state;

    logic        wait_done;
    logic        taken;
    logic [7:0]  ir_hi_q;
    logic [7:0]  ir_lo_q;
    logic [15:0] target_q;

    logic rom_out_n_q;
    logic pchitmp_n_q;
    logic pclo_n_q;
    logic pchi_n_q;

    reset_wait_counter #(
        .RESET_WAIT(RESET_WAIT)
    ) u_reset_wait (
        .clk (CP),
        .rst (MR),
        .en  (state == ST_WAIT),
        .done(wait_done)
    );

    // Low condition nibble of the jump opcode selects which flags gate the jump.
    assign taken = jump_taken(ir_lo_q[COND_W-1:0], bus.flags);

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        next_state      = state;
        bus.pc_count_en = 1'b0;
        bus.ir_valid    = 1'b0;
        bus.D           = 8'h00;

        unique case (state)
            ST_WAIT: begin
                if (wait_done) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                bus.pc_count_en = 1'b1;
                next_state = (bus.rom_hi_data[7:4] == JMP_NIBBLE) ? ST_TGT : ST_EXEC;
            end
            ST_EXEC: begin
                bus.ir_valid = 1'b1;
                if (!bus.hold) next_state = ST_FETCH;
            end
            ST_TGT: begin
                // Untaken jumps step PC over the target word.
                bus.pc_count_en = !taken;
                next_state = taken ? ST_LDHI : ST_FETCH;
            end
            ST_LDHI: begin
                bus.D      = target_q[15:8];
                next_state = ST_LDLO;
            end
            ST_LDLO: begin
                bus.D      = target_q[7:0];
                next_state = ST_FETCH;
            end
            default: begin
                next_state = ST_WAIT;
            end
        endcase
    end

    // Strobes and ROM enable are flops decoded from next_state, so they change glitch-free at the edge.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            rom_out_n_q <= 1'b1;
            pchitmp_n_q <= 1'b1;
            pclo_n_q    <= 1'b1;
            pchi_n_q    <= 1'b1;
        end else begin
            rom_out_n_q <= !((next_state == ST_FETCH) || (next_state == ST_TGT));
            pchitmp_n_q <= (next_state != ST_LDHI);
            pclo_n_q    <= (next_state != ST_LDLO);
            pchi_n_q    <= (next_state != ST_LDLO);
        end
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            ir_hi_q  <= 8'h00;
            ir_lo_q  <= 8'h00;
            target_q <= 16'h0000;
        end else begin
            if (state == ST_FETCH) begin
                ir_hi_q <= bus.rom_hi_data;
                ir_lo_q <= bus.rom_lo_data;
            end
            if (state == ST_TGT) begin
                target_q <= {bus.rom_hi_data, bus.rom_lo_data};
            end
        end
    end

    // PC is 16 bits wide but the ROM only decodes AWIDTH bits; upper PC bits simply wrap away.
    assign bus.rom_address = {bus.PCHI[AWIDTH-9:0], bus.PCLO};

    generate
        if (AWIDTH < 16) begin : g_pchi_unused
            logic unused_pchi;
            assign unused_pchi = ^bus.PCHI[7:AWIDTH-8];
        end
    endgenerate

    assign bus._rom_out   = rom_out_n_q;
    assign bus._PCHITMPin = pchitmp_n_q;
    assign bus._PCLOin    = pclo_n_q;
    assign bus._PCHIin    = pchi_n_q;
    assign bus.IR_HI      = ir_hi_q;
    assign bus.IR_LO      = ir_lo_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural PC register and ROM pair.
module tb_fetch_sequencer;

    localparam int unsigned AWIDTH     = 15;
    localparam int unsigned RESET_WAIT = 2;

    // {_rom_out, pc_count_en, _PCHITMPin, _PCLOin, _PCHIin, ir_valid}
    localparam logic [5:0] CTL_IDLE      = 6'b1_0_111_0;
    localparam logic [5:0] CTL_FETCH     = 6'b0_1_111_0;
    localparam logic [5:0] CTL_EXEC      = 6'b1_0_111_1;
    localparam logic [5:0] CTL_TGT_TAKEN = 6'b0_0_111_0;
    localparam logic [5:0] CTL_TGT_SKIP  = 6'b0_1_111_0;
    localparam logic [5:0] CTL_LDHI      = 6'b1_0_011_0;
    localparam logic [5:0] CTL_LDLO      = 6'b1_0_100_0;

    logic CP;
    logic MR;

    fetch_sequencer_if #(.AWIDTH(AWIDTH)) bus ();

    fetch_sequencer #(
        .AWIDTH    (AWIDTH),
        .RESET_WAIT(RESET_WAIT)
    ) dut (
        .CP (CP),
        .MR (MR),
        .bus(bus)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Behavioural PC with PCHITMP staging register, and a 32K-word ROM pair.
    logic [15:0] pc;
    logic [7:0]  pchitmp;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] rom [0:32767];

    always @(posedge CP) begin
        if (pc_load) begin
            pc <= pc_load_val;
        end else begin
            if (!bus._PCHITMPin) pchitmp <= bus.D;
            if (!bus._PCLOin)    pc[7:0]  <= bus.D;
            if (!bus._PCHIin)    pc[15:8] <= pchitmp;
            if (bus.pc_count_en) pc <= pc + 16'd1;
        end
    end

    assign bus.PCHI        = pc[15:8];
    assign bus.PCLO        = pc[7:0];
    assign bus.rom_hi_data = rom[bus.rom_address][15:8];
    assign bus.rom_lo_data = rom[bus.rom_address][7:0];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] lin_words [4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {bus._rom_out, bus.pc_count_en, bus._PCHITMPin, bus._PCLOin, bus._PCHIin, bus.ir_valid};
    endfunction

    task automatic step();
        @(negedge CP);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset(input logic preload, input logic [15:0] start, input int cycles);
        MR          = 1'b1;
        pc_load     = preload;
        pc_load_val = start;
        repeat (cycles) step();
        MR      = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        repeat (RESET_WAIT) begin
            step();
            check({tag, "_idle"}, 32'(ctl()), 32'(CTL_IDLE));
        end
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        check({tag, "_ctl"},  32'(ctl()), 32'(CTL_FETCH));
        check({tag, "_addr"}, 32'(bus.rom_address), addr);
    endtask

    task automatic expect_exec(input string tag, input logic [31:0] ir);
        check({tag, "_ctl"}, 32'(ctl()), 32'(CTL_EXEC));
        check({tag, "_ir"},  32'({bus.IR_HI, bus.IR_LO}), ir);
    endtask

    initial begin
        MR          = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'h0000;
        bus.hold    = 1'b0;
        bus.flags   = 4'b0000;
        clear_rom();

        // Reset, then linear fetch of four plain instructions.
        for (int i = 0; i < 4; i++) rom[i] = lin_words[i];
        repeat (19) step();
        check("rst_ctl", 32'(ctl()), 32'(CTL_IDLE));
        check("rst_ir",  32'({bus.IR_HI, bus.IR_LO}), 32'h0);
        check("rst_d",   32'(bus.D), 32'h0);
        step();
        MR      = 1'b0;
        pc_load = 1'b0;
        wait_idle("lin");
        for (int i = 0; i < 4; i++) begin
            step(); expect_fetch("lin_fetch", 32'(i));
            step(); expect_exec("lin_exec", 32'(lin_words[i]));
        end

        // Unconditional jump to 0x1234.
        clear_rom();
        rom[0] = 16'hF000; rom[1] = 16'h1234; rom['h1234] = 16'h0A0B;
        do_reset(1'b1, 16'h0000, 2);
        wait_idle("jmp");
        step(); expect_fetch("jmp_fetch", 32'h0);
        step(); check("jmp_tgt_ctl", 32'(ctl()), 32'(CTL_TGT_TAKEN));
                check("jmp_tgt_addr", 32'(bus.rom_address), 32'h1);
                check("jmp_tgt_d", 32'(bus.D), 32'h0);
        step(); check("jmp_ldhi_ctl", 32'(ctl()), 32'(CTL_LDHI));
                check("jmp_ldhi_d", 32'(bus.D), 32'h12);
        step(); check("jmp_ldlo_ctl", 32'(ctl()), 32'(CTL_LDLO));
                check("jmp_ldlo_d", 32'(bus.D), 32'h34);
        step(); expect_fetch("jmp_dst", 32'h1234);
                check("jmp_dst_d", 32'(bus.D), 32'h0);
        step(); expect_exec("jmp_exec", 32'h0A0B);

        // Conditional jump, condition false: target word skipped.
        clear_rom();
        rom[0] = 16'hF002; rom[1] = 16'hABCD; rom[2] = 16'h1122; rom['h2BCD] = 16'h3344;
        bus.flags = 4'b0000;
        do_reset(1'b1, 16'h0000, 2);
        wait_idle("nt");
        step(); expect_fetch("nt_fetch", 32'h0);
        step(); check("nt_tgt_ctl", 32'(ctl()), 32'(CTL_TGT_SKIP));
                check("nt_tgt_addr", 32'(bus.rom_address), 32'h1);
        step(); expect_fetch("nt_next", 32'h2);
        step(); expect_exec("nt_exec", 32'h1122);

        // Same jump, condition true: 0xABCD truncates to ROM address 0x2BCD.
        bus.flags = 4'b0010;
        do_reset(1'b1, 16'h0000, 2);
        wait_idle("tk");
        step(); expect_fetch("tk_fetch", 32'h0);
        step(); check("tk_tgt_ctl", 32'(ctl()), 32'(CTL_TGT_TAKEN));
        step(); check("tk_ldhi_ctl", 32'(ctl()), 32'(CTL_LDHI));
                check("tk_ldhi_d", 32'(bus.D), 32'hAB);
        step(); check("tk_ldlo_ctl", 32'(ctl()), 32'(CTL_LDLO));
                check("tk_ldlo_d", 32'(bus.D), 32'hCD);
        step(); expect_fetch("tk_dst", 32'h2BCD);
        step(); expect_exec("tk_exec", 32'h3344);
        bus.flags = 4'b0000;

        // Stall in EXEC for three edges.
        clear_rom();
        rom[0] = 16'h4455; rom[1] = 16'h6677;
        do_reset(1'b1, 16'h0000, 2);
        wait_idle("hold");
        step(); expect_fetch("hold_fetch", 32'h0);
        step(); expect_exec("hold_exec", 32'h4455);
        bus.hold = 1'b1;
        repeat (3) begin
            step(); expect_exec("hold_stall", 32'h4455);
            check("hold_pc", 32'(bus.rom_address), 32'h1);
        end
        bus.hold = 1'b0;
        step(); expect_fetch("hold_resume", 32'h1);
        step(); expect_exec("hold_exec2", 32'h6677);

        // Address wrap at 0x7FFF; hold during FETCH has no effect.
        clear_rom();
        rom['h7FFF] = 16'h5A5A; rom[0] = 16'h0C0D;
        do_reset(1'b1, 16'h7FFF, 2);
        wait_idle("wrap");
        step(); expect_fetch("wrap_fetch", 32'h7FFF);
        bus.hold = 1'b1;
        step(); expect_exec("wrap_exec", 32'h5A5A);
        bus.hold = 1'b0;
        step(); expect_fetch("wrap_next", 32'h0);
        step(); expect_exec("wrap_exec2", 32'h0C0D);

        // MR during LDLO: strobes drop at once and PC stays unloaded.
        clear_rom();
        rom[0] = 16'hF000; rom[1] = 16'h1234;
        do_reset(1'b1, 16'h0000, 2);
        wait_idle("mr");
        step(); expect_fetch("mr_fetch", 32'h0);
        step(); check("mr_tgt_ctl", 32'(ctl()), 32'(CTL_TGT_TAKEN));
        step(); check("mr_ldhi_ctl", 32'(ctl()), 32'(CTL_LDHI));
        step(); check("mr_ldlo_ctl", 32'(ctl()), 32'(CTL_LDLO));
        MR = 1'b1;
        #1;
        check("mr_async_ctl", 32'(ctl()), 32'(CTL_IDLE));
        check("mr_async_d",   32'(bus.D), 32'h0);
        do_reset(1'b0, 16'h0000, 2);
        wait_idle("mr_post");
        step(); expect_fetch("mr_refetch", 32'h1);
        step(); expect_exec("mr_exec", 32'h1234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
